// File: rtl/branch_pkg.sv
// Shared definitions for the branch/PC sequencer: opcodes,
// instruction field positions and FSM state encoding.
package branch_pkg;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int OFF_HI = 20;
    localparam int OFF_LO = 0;

    localparam logic [5:0] OP_B    = 6'b100000;
    localparam logic [5:0] OP_BL   = 6'b100001;
    localparam logic [5:0] OP_BZ   = 6'b100010;
    localparam logic [5:0] OP_BNZ  = 6'b100011;
    localparam logic [5:0] OP_BLTZ = 6'b100100;
    localparam logic [5:0] OP_BR   = 6'b100101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        READ   = 2'd2,
        UPDATE = 2'd3
    } state_t;

    // Branches whose outcome or target depends on a register value
    function automatic logic is_reg_br(input logic [5:0] op);
        return (op == OP_BZ) || (op == OP_BNZ) ||
               (op == OP_BLTZ) || (op == OP_BR);
    endfunction

endpackage

// File: rtl/branch_pc_sequencer_imm21_sext.sv
// Sign extension of the branch offset field to datapath width.
module imm21_sext #(
    parameter int OFF_W = 21,
    parameter int XLEN  = 32
) (
    input  logic [OFF_W-1:0] off,
    output logic [XLEN-1:0]  sext
);

    assign sext = {{(XLEN-OFF_W){off[OFF_W-1]}}, off};

endmodule

// File: rtl/branch_pc_sequencer.sv
// Program counter owner: accepts one instruction at a time, resolves
// branches (reading the register file when needed) and commits the PC.
module branch_pc_sequencer
    import branch_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter int          OFF_W    = 21,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [4:0]  LINK_REG = 5'd31
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    input  logic [31:0]     instr,
    output logic            instr_ready,
    output logic [4:0]      rf_raddr,
    input  logic [XLEN-1:0] rf_rdata,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] next_pc,
    output logic            pc_update,
    output logic            taken,
    output logic            link_we,
    output logic [4:0]      link_waddr,
    output logic [XLEN-1:0] link_wdata,
    output logic            busy
);

    state_t          state_q, state_d;
    logic [31:0]     ir_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] npc_q, npc_d;
    logic            tkn_q, tkn_d;
    logic            latch;

    logic [5:0]       op;
    logic [4:0]       rs;
    logic [OFF_W-1:0] off;
    logic [XLEN-1:0]  sext;
    logic [XLEN-1:0]  fall;
    logic [XLEN-1:0]  tgt;
    logic             reg_br;

    assign op     = ir_q[OPC_HI:OPC_LO];
    assign rs     = ir_q[RS_HI:RS_LO];
    assign off    = ir_q[OFF_HI:OFF_LO];
    assign reg_br = is_reg_br(op);

    imm21_sext #(
        .OFF_W (OFF_W),
        .XLEN  (XLEN)
    ) u_sext (
        .off  (off),
        .sext (sext)
    );

    // Byte offset relative to the fall-through address; wraps mod 2^XLEN
    assign fall = pc_q + XLEN'(4);
    assign tgt  = fall + sext;

    always_comb begin
        state_d = state_q;
        npc_d   = npc_q;
        tkn_d   = tkn_q;
        latch   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    latch   = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (reg_br) begin
                    state_d = READ;
                end else begin
                    tkn_d   = (op == OP_B) || (op == OP_BL);
                    npc_d   = tkn_d ? tgt : fall;
                    state_d = UPDATE;
                end
            end
            READ: begin
                unique case (1'b1)
                    (op == OP_BZ):   tkn_d = (rf_rdata == '0);
                    (op == OP_BNZ):  tkn_d = (rf_rdata != '0);
                    (op == OP_BLTZ): tkn_d = rf_rdata[XLEN-1];
                    (op == OP_BR):   tkn_d = 1'b1;
                    default:         tkn_d = 1'b0;
                endcase
                if (op == OP_BR) begin
                    npc_d = rf_rdata;
                end else begin
                    npc_d = tkn_d ? tgt : fall;
                end
                state_d = UPDATE;
            end
            UPDATE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ir_q    <= '0;
            pc_q    <= RESET_PC;
            npc_q   <= '0;
            tkn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            npc_q   <= npc_d;
            tkn_q   <= tkn_d;
            if (latch) begin
                ir_q <= instr;
            end
            if (state_q == UPDATE) begin
                pc_q <= npc_q;
            end
        end
    end

    assign instr_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign pc_update   = (state_q == UPDATE);
    assign taken       = pc_update & tkn_q;
    assign link_we     = pc_update & (op == OP_BL);
    assign link_waddr  = LINK_REG;
    assign link_wdata  = fall;
    assign pc_out      = pc_q;
    assign next_pc     = npc_q;
    assign rf_raddr    = (reg_br && (state_q == DECODE || state_q == READ))
                         ? rs : 5'd0;

endmodule
